// File: rtl/vec_mem_seq.sv
// Vector memory sequencer: gathers lanes from byte memory (VLOAD), scatters lanes
// to memory (VSTORE), or forms lane-wise sums (VADD), then strobes write-back.
module vec_mem_seq #(
    parameter int WIDTH  = 8,
    parameter int STRIDE = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     base_addr,
    input  logic [4*WIDTH-1:0]   a_data,
    input  logic [4*WIDTH-1:0]   b_data,
    input  logic [WIDTH-1:0]     mem_q,
    output logic [WIDTH-1:0]     mem_addr,
    output logic                 mem_read,
    output logic                 mem_wren,
    output logic [WIDTH-1:0]     mem_data,
    output logic [4*WIDTH-1:0]   vdataw,
    output logic                 vrf_write,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_STORE = 2'b01,
        OP_ADD   = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD,
        S_LD_TAIL,
        S_ST,
        S_ADD,
        S_WB
    } state_e;

    state_e               state_q;
    logic [1:0]           idx_q;
    logic [WIDTH-1:0]     base_q;
    logic [4*WIDTH-1:0]   a_q;
    logic [4*WIDTH-1:0]   b_q;
    logic [4*WIDTH-1:0]   t_q;
    logic [WIDTH-1:0]     mem_addr_q;
    logic [WIDTH-1:0]     mem_data_q;
    logic                 mem_read_q;
    logic                 mem_wren_q;
    logic                 vrf_write_q;
    logic                 busy_q;
    logic                 done_q;

    // Lane 0 occupies the most significant byte of the vector.
    function automatic int lane_lsb(input logic [1:0] lane);
        return (3 - int'(lane)) * WIDTH;
    endfunction

    function automatic logic [WIDTH-1:0] lane_of(input logic [4*WIDTH-1:0] vec,
                                                 input logic [1:0]         lane);
        return vec[lane_lsb(lane) +: WIDTH];
    endfunction

    function automatic logic [WIDTH-1:0] lane_addr(input logic [WIDTH-1:0] base,
                                                   input logic [1:0]       lane);
        return base + WIDTH'(STRIDE * int'(lane));
    endfunction

    // NOTE: all state, including outputs, updates with <= so every register sees
    // the pre-edge values of the others regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            base_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            t_q         <= '0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            mem_read_q  <= 1'b0;
            mem_wren_q  <= 1'b0;
            vrf_write_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && op != OP_RSVD) begin
                        base_q <= base_addr;
                        a_q    <= a_data;
                        b_q    <= b_data;
                        idx_q  <= '0;
                        busy_q <= 1'b1;
                        case (op)
                            OP_LOAD: begin
                                state_q    <= S_LD;
                                mem_read_q <= 1'b1;
                                mem_addr_q <= base_addr;
                            end
                            OP_STORE: begin
                                state_q    <= S_ST;
                                mem_wren_q <= 1'b1;
                                mem_addr_q <= base_addr;
                                mem_data_q <= lane_of(a_data, 2'd0);
                            end
                            default: begin
                                state_q <= S_ADD;
                            end
                        endcase
                    end
                end

                S_LD: begin
                    // Read data trails the address by one cycle, so lane idx-1 lands now.
                    if (idx_q != 2'd0) begin
                        t_q[lane_lsb(idx_q - 2'd1) +: WIDTH] <= mem_q;
                    end
                    if (idx_q == 2'd3) begin
                        state_q    <= S_LD_TAIL;
                        mem_read_q <= 1'b0;
                        mem_addr_q <= '0;
                    end else begin
                        idx_q      <= idx_q + 2'd1;
                        mem_addr_q <= lane_addr(base_q, idx_q + 2'd1);
                    end
                end

                S_LD_TAIL: begin
                    t_q[lane_lsb(2'd3) +: WIDTH] <= mem_q;
                    state_q     <= S_WB;
                    vrf_write_q <= 1'b1;
                    done_q      <= 1'b1;
                end

                S_ST: begin
                    if (idx_q == 2'd3) begin
                        state_q    <= S_IDLE;
                        mem_wren_q <= 1'b0;
                        mem_addr_q <= '0;
                        mem_data_q <= '0;
                        done_q     <= 1'b0;
                        busy_q     <= 1'b0;
                    end else begin
                        idx_q      <= idx_q + 2'd1;
                        mem_addr_q <= lane_addr(base_q, idx_q + 2'd1);
                        mem_data_q <= lane_of(a_q, idx_q + 2'd1);
                        done_q     <= (idx_q == 2'd2);
                    end
                end

                S_ADD: begin
                    for (int i = 0; i < 4; i++) begin
                        t_q[i*WIDTH +: WIDTH] <= a_q[i*WIDTH +: WIDTH] + b_q[i*WIDTH +: WIDTH];
                    end
                    state_q     <= S_WB;
                    vrf_write_q <= 1'b1;
                    done_q      <= 1'b1;
                end

                S_WB: begin
                    state_q     <= S_IDLE;
                    vrf_write_q <= 1'b0;
                    done_q      <= 1'b0;
                    busy_q      <= 1'b0;
                end

                default: begin
                    state_q     <= S_IDLE;
                    mem_read_q  <= 1'b0;
                    mem_wren_q  <= 1'b0;
                    mem_addr_q  <= '0;
                    mem_data_q  <= '0;
                    vrf_write_q <= 1'b0;
                    done_q      <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_read  = mem_read_q;
    assign mem_wren  = mem_wren_q;
    assign mem_data  = mem_data_q;
    assign vdataw    = t_q;
    assign vrf_write = vrf_write_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_vec_mem_seq.sv
// Self-checking bench for vec_mem_seq: byte memory device plus a lane-level
// reference model predicting every output cycle by cycle.
module tb_vec_mem_seq;

    localparam int WIDTH  = 8;
    localparam int STRIDE = 1;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [7:0]  base_addr = 8'h00;
    logic [31:0] a_data = 32'h0;
    logic [31:0] b_data = 32'h0;
    logic [7:0]  mem_q;
    logic [7:0]  mem_addr;
    logic        mem_read;
    logic        mem_wren;
    logic [7:0]  mem_data;
    logic [31:0] vdataw;
    logic        vrf_write;
    logic        busy;
    logic        done;

    vec_mem_seq #(.WIDTH(WIDTH), .STRIDE(STRIDE)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .base_addr (base_addr),
        .a_data    (a_data),
        .b_data    (b_data),
        .mem_q     (mem_q),
        .mem_addr  (mem_addr),
        .mem_read  (mem_read),
        .mem_wren  (mem_wren),
        .mem_data  (mem_data),
        .vdataw    (vdataw),
        .vrf_write (vrf_write),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    // Data memory device: one-cycle read latency, synchronous write.
    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    logic [7:0] rd_q = 8'h00;

    always @(posedge clock) begin
        if (mem_read) rd_q <= mem[mem_addr];
        if (mem_wren) mem[mem_addr] <= mem_data;
    end
    assign mem_q = rd_q;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_v = 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] addr_of(input logic [7:0] base, input int i);
        return 8'(int'(base) + i * STRIDE);
    endfunction

    function automatic logic [7:0] byte_of(input logic [31:0] v, input int i);
        return v[(3 - i) * 8 +: 8];
    endfunction

    task automatic check_idle(input string tag);
        check({tag, " busy"},      32'(busy),      32'd0);
        check({tag, " done"},      32'(done),      32'd0);
        check({tag, " vrf_write"}, 32'(vrf_write), 32'd0);
        check({tag, " mem_read"},  32'(mem_read),  32'd0);
        check({tag, " mem_wren"},  32'(mem_wren),  32'd0);
        check({tag, " mem_addr"},  32'(mem_addr),  32'd0);
        check({tag, " mem_data"},  32'(mem_data),  32'd0);
        check({tag, " vdataw"},    vdataw,         exp_v);
    endtask

    task automatic check_mem_image(input string tag);
        int diff = 0;
        for (int k = 0; k < 256; k++) begin
            if (mem[k] !== ref_mem[k]) diff++;
        end
        check({tag, " mem_image_diffs"}, 32'(diff), 32'd0);
    endtask

    // Caller must be just past a falling edge; this cycle becomes cycle 0.
    task automatic do_op(input string name, input logic [1:0] o, input logic [7:0] base,
                         input logic [31:0] a, input logic [31:0] b, input bit disturb);
        bit          is_ld = (o == 2'b00);
        bit          is_st = (o == 2'b01);
        int          last  = is_ld ? 6 : (is_st ? 4 : 2);
        logic [31:0] new_v = exp_v;
        bit          active;
        string       t;

        if (is_ld) begin
            for (int i = 0; i < 4; i++) new_v[(3 - i) * 8 +: 8] = ref_mem[addr_of(base, i)];
        end else if (!is_st) begin
            for (int i = 0; i < 4; i++) new_v[(3 - i) * 8 +: 8] = 8'(byte_of(a, i) + byte_of(b, i));
        end

        start     = 1'b1;
        op        = o;
        base_addr = base;
        a_data    = a;
        b_data    = b;

        for (int c = 1; c <= last + 1; c++) begin
            @(negedge clock);
            t = $sformatf("%s c%0d", name, c);
            active = (is_ld || is_st) && c <= 4;
            check({t, " busy"},      32'(busy),      32'(c <= last));
            check({t, " done"},      32'(done),      32'(c == last));
            check({t, " vrf_write"}, 32'(vrf_write), 32'(!is_st && c == last));
            check({t, " mem_read"},  32'(mem_read),  32'(is_ld && c <= 4));
            check({t, " mem_wren"},  32'(mem_wren),  32'(is_st && c <= 4));
            check({t, " mem_addr"},  32'(mem_addr),  active ? 32'(addr_of(base, c - 1)) : 32'd0);
            check({t, " mem_data"},  32'(mem_data),  (is_st && c <= 4) ? 32'(byte_of(a, c - 1)) : 32'd0);
            if (is_st || c >= last) check({t, " vdataw"}, vdataw, new_v);

            start = disturb && (c == 2 || c == 3);
            if (disturb && c >= 2) begin
                a_data    = ~a;
                b_data    = ~b;
                base_addr = base ^ 8'h5A;
                if (start) op = 2'($urandom_range(0, 2));
            end
        end

        exp_v = new_v;
        if (is_st) begin
            for (int i = 0; i < 4; i++) ref_mem[addr_of(base, i)] = byte_of(a, i);
        end
        check_mem_image(name);
    endtask

    initial begin
        for (int k = 0; k < 256; k++) begin
            mem[k]     = 8'($urandom);
            ref_mem[k] = mem[k];
        end

        // Reset and idle.
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check_idle("reset");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check_idle($sformatf("idle%0d", i));
        end

        // Reserved opcode is ignored.
        start = 1'b1;
        op    = 2'b11;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_idle($sformatf("rsvd%0d", i));
            @(negedge clock);
        end

        // Directed VLOAD.
        for (int i = 0; i < 4; i++) begin
            mem[8'h10 + i]     = 8'(8'h11 * (i + 1));
            ref_mem[8'h10 + i] = 8'(8'h11 * (i + 1));
        end
        do_op("vload_dir", 2'b00, 8'h10, 32'h0, 32'h0, 1'b0);
        check("vload_dir value", vdataw, 32'h11223344);

        // Directed VSTORE across the address wrap.
        do_op("vstore_wrap", 2'b01, 8'hFE, 32'hA1B2C3D4, 32'h0, 1'b0);
        check("vstore_wrap mem_FE_FF_00_01",
              {mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01]}, 32'hA1B2C3D4);

        // Directed VADD with per-lane wrap.
        do_op("vadd_dir", 2'b10, 8'h00, 32'hFF017F80, 32'h0101017F, 1'b0);
        check("vadd_dir value", vdataw, 32'h000280FF);

        // Reset in cycle 3 of a VLOAD.
        start     = 1'b1;
        op        = 2'b00;
        base_addr = 8'h40;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_v = 32'h0;
        for (int i = 0; i < 6; i++) begin
            check_idle($sformatf("abort%0d", i));
            @(negedge clock);
        end
        check_mem_image("abort");
        do_op("vstore_after_abort", 2'b01, 8'h80, 32'h5566_7788, 32'h0, 1'b0);

        // Start re-pulsed and operands changed mid-VSTORE.
        do_op("vstore_disturb", 2'b01, 8'h20, 32'hDEADBEEF, 32'h0, 1'b1);

        // Randomized back-to-back traffic.
        for (int n = 0; n < 24; n++) begin
            do_op($sformatf("rand%0d", n), 2'($urandom_range(0, 2)), 8'($urandom),
                  $urandom, $urandom, $urandom_range(0, 3) == 0);
        end

        @(negedge clock);
        check_idle("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
